bcd_counter_ndigit: RTL and testbench

//  Parametrised N-digit cascadable BCD up/down counter. Adds direction control,

---
 rtl/bcd_counter_ndigit.sv | 129 ++++++++++++
 tb/tb_bcd_counter_ndigit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_ndigit.sv
// Purpose : N-digit cascadable BCD up/down counter with clear, load and sticky wrap.
// Latency : q updates on the edge after Cin/Load/Clr is sampled; Cout is combinational.
// Backpres: none; the counter accepts one step, load or clear on every clock edge.
//
// Ports:
//   Clk, Rst_n      rising-edge clock, asynchronous active-low reset
//   Cin             count enable / carry-in, one step per cycle
//   Up              1 = count up, 0 = count down
//   Clr             synchronous clear to RST_VAL in every digit (highest priority)
//   Load, Load_val  synchronous parallel load (priority below Clr, above Cin)
//   q               packed BCD value, digit 0 in q[3:0]
//   Cout            Cin & terminal count (all 9 going up, all 0 going down)
//   Wrap            sticky: set by a wrapping step, cleared by Clr or reset
//   Load_err        one-cycle pulse when a load is rejected
//
// Build option: define BCD_CNT_LOAD_CHECK_EN to reject loads that contain a
// nibble above 9 (q and Wrap held, Load_err pulses). Without it, Load_val is
// loaded verbatim and Load_err stays 0.

module bcd_counter_ndigit #(
    parameter int DIGITS  = 4,
    parameter int RST_VAL = 0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Cin,
    input  logic                  Up,
    input  logic                  Clr,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  Cout,
    output logic                  Wrap,
    output logic                  Load_err
);

    localparam int              W       = 4 * DIGITS;
    localparam logic [3:0]      RST_DIG = 4'(RST_VAL);
    localparam logic [W-1:0]    RST_VEC = {DIGITS{RST_DIG}};

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] cnt_step;
    logic [3:0]   dig;
    logic         run9, run0;
    logic         all9, all0;
    logic         load_bad;

    // Ripple carry/borrow resolved in one cycle. run9/run0 track whether every
    // digit below the current one is 9/0; an illegal digit (>9) breaks both
    // chains, so it never propagates a carry or borrow upward.
    always_comb begin
        cnt_step = cnt_q;
        dig      = 4'd0;
        run9     = 1'b1;
        run0     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            dig = cnt_q[4*k +: 4];
            if (Up ? run9 : run0) begin
                if (Up) begin
                    // 9 and illegal values both roll to 0
                    cnt_step[4*k +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
                end else begin
                    // 0 and illegal values both roll to 9
                    cnt_step[4*k +: 4] = ((dig == 4'd0) || (dig > 4'd9)) ? 4'd9 : dig - 4'd1;
                end
            end
            run9 = run9 & (dig == 4'd9);
            run0 = run0 & (dig == 4'd0);
        end
        all9 = run9;
        all0 = run0;
    end

    assign Cout = Cin & (Up ? all9 : all0);

    always_comb begin
        load_bad = 1'b0;
`ifdef BCD_CNT_LOAD_CHECK_EN
        for (int k = 0; k < DIGITS; k++) begin
            if (Load_val[4*k +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end
        end
`endif
    end

    // Priority: Clr > Load > Cin; idle holds everything.
    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = wrap_q;
        load_err_d = 1'b0;
        if (Clr) begin
            cnt_d  = RST_VEC;
            wrap_d = 1'b0;
        end else if (Load) begin
            if (load_bad) begin
                load_err_d = 1'b1;
            end else begin
                cnt_d = Load_val;
            end
        end else if (Cin) begin
            cnt_d = cnt_step;
            // Cout high here means this step wraps the whole counter
            if (Cout) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q      <= RST_VEC;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = cnt_q;
    assign Wrap     = wrap_q;
    assign Load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Purpose : bench for bcd_counter_ndigit (4-digit main instance plus a 2x2-digit cascade).
// Latency : a decimal-arithmetic reference advances on each edge; outputs compared every negedge.
// Backpres: n/a.

module tb_bcd_counter_ndigit;

`ifdef BCD_CNT_LOAD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Cin = 1'b0;
    logic        Up = 1'b1;
    logic        Clr = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Load_val = 16'h0000;
    logic [15:0] q;
    logic        Cout, Wrap, Load_err;

    // cascade pair
    logic        c_cin = 1'b0;
    logic        c_up = 1'b1;
    logic        c_zero = 1'b0;
    logic [7:0]  c_lval = 8'h00;
    logic [7:0]  lo_q, hi_q;
    logic        lo_cout, hi_cout, lo_wrap, hi_wrap, lo_err, hi_err;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    bcd_counter_ndigit #(.DIGITS(4), .RST_VAL(0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Cin(Cin), .Up(Up), .Clr(Clr), .Load(Load),
        .Load_val(Load_val), .q(q), .Cout(Cout), .Wrap(Wrap), .Load_err(Load_err)
    );

    bcd_counter_ndigit #(.DIGITS(2), .RST_VAL(0)) u_lo (
        .Clk(Clk), .Rst_n(Rst_n), .Cin(c_cin), .Up(c_up), .Clr(c_zero), .Load(c_zero),
        .Load_val(c_lval), .q(lo_q), .Cout(lo_cout), .Wrap(lo_wrap), .Load_err(lo_err)
    );

    bcd_counter_ndigit #(.DIGITS(2), .RST_VAL(0)) u_hi (
        .Clk(Clk), .Rst_n(Rst_n), .Cin(lo_cout), .Up(c_up), .Clr(c_zero), .Load(c_zero),
        .Load_val(c_lval), .q(hi_q), .Cout(hi_cout), .Wrap(hi_wrap), .Load_err(hi_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Legal values: plain decimal arithmetic modulo 10^4. Values holding an
    // illegal nibble fall back to the digit-by-digit rules.
    function automatic logic [15:0] m_next(input logic [15:0] cur, input bit upd);
        int d[4];
        int v;
        bit valid;
        bit carry;
        logic [15:0] r;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d[k] = int'(cur[4*k +: 4]);
            if (d[k] > 9) valid = 1'b0;
        end
        if (valid) begin
            v = 0;
            for (int k = 3; k >= 0; k--) v = v * 10 + d[k];
            v = upd ? (v + 1) % 10000 : (v + 9999) % 10000;
            for (int k = 0; k < 4; k++) begin
                d[k] = v % 10;
                v    = v / 10;
            end
        end else begin
            carry = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (carry) begin
                    if (upd) begin
                        if (d[k] == 9) d[k] = 0;
                        else if (d[k] > 9) begin d[k] = 0; carry = 1'b0; end
                        else begin d[k] = d[k] + 1; carry = 1'b0; end
                    end else begin
                        if (d[k] == 0) d[k] = 9;
                        else if (d[k] > 9) begin d[k] = 9; carry = 1'b0; end
                        else begin d[k] = d[k] - 1; carry = 1'b0; end
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'(d[k]);
        return r;
    endfunction

    function automatic bit m_term(input logic [15:0] cur, input bit upd);
        return upd ? (cur == 16'h9999) : (cur == 16'h0000);
    endfunction

    function automatic bit m_bad(input logic [15:0] v);
        bit b;
        b = 1'b0;
        for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    logic [15:0] m_q;
    logic        m_wrap, m_err;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_q    <= 16'h0000;
            m_wrap <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (Clr) begin
                m_q    <= 16'h0000;
                m_wrap <= 1'b0;
            end else if (Load) begin
                if (CHK && m_bad(Load_val)) m_err <= 1'b1;
                else                        m_q   <= Load_val;
            end else if (Cin) begin
                m_q <= m_next(m_q, Up);
                if (m_term(m_q, Up)) m_wrap <= 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        check("q", 32'(q), 32'(m_q));
        check("wrap", 32'(Wrap), 32'(m_wrap));
        check("load_err", 32'(Load_err), 32'(m_err));
        check("cout", 32'(Cout), 32'(Cin & m_term(m_q, Up)));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #2;
        check("reset_q", 32'(q), 32'h0);
        check("reset_wrap", 32'(Wrap), 32'h0);
        check("reset_err", 32'(Load_err), 32'h0);
        Rst_n = 1'b1;
        cyc();

        // up ripple
        Load = 1'b1; Load_val = 16'h0199;
        cyc();
        check("load_0199", 32'(q), 32'h0199);
        Load = 1'b0; Cin = 1'b1; Up = 1'b1;
        cyc();
        check("up_ripple_q", 32'(q), 32'h0200);
        check("up_ripple_cout", 32'(Cout), 32'h0);
        Cin = 1'b0; Load = 1'b1; Load_val = 16'h9999;
        cyc();
        Load = 1'b0; Cin = 1'b1;
        #1;
        check("up_wrap_cout", 32'(Cout), 32'h1);
        cyc();
        check("up_wrap_q", 32'(q), 32'h0000);
        check("up_wrap_flag", 32'(Wrap), 32'h1);

        // asynchronous reset mid-count
        cyc();
        cyc();
        #1 Rst_n = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 32'h0000);
        check("async_rst_wrap", 32'(Wrap), 32'h0);
        cyc();
        Rst_n = 1'b1;
        cyc();
        check("resume_q", 32'(q), 32'h0001);
        Cin = 1'b0;

        // down borrow
        Load = 1'b1; Load_val = 16'h1000;
        cyc();
        Load = 1'b0; Up = 1'b0; Cin = 1'b1;
        cyc();
        check("down_borrow_q", 32'(q), 32'h0999);
        Cin = 1'b0; Load = 1'b1; Load_val = 16'h0000;
        cyc();
        Load = 1'b0; Cin = 1'b1; Up = 1'b0;
        #1;
        check("down_wrap_cout", 32'(Cout), 32'h1);
        cyc();
        check("down_wrap_q", 32'(q), 32'h9999);
        check("down_wrap_flag", 32'(Wrap), 32'h1);

        // priority
        Clr = 1'b1; Load = 1'b1; Cin = 1'b1; Load_val = 16'h5555;
        cyc();
        check("clr_prio_q", 32'(q), 32'h0000);
        check("clr_prio_wrap", 32'(Wrap), 32'h0);
        Clr = 1'b0; Load = 1'b1; Cin = 1'b1; Up = 1'b1; Load_val = 16'h4321;
        cyc();
        check("load_prio_q", 32'(q), 32'h4321);
        Load = 1'b0; Cin = 1'b0; Up = 1'b0;
        cyc();
        Up = 1'b1;
        cyc();
        check("idle_hold_q", 32'(q), 32'h4321);

        // illegal nibble load
        Load = 1'b1; Load_val = 16'h12A4;
        cyc();
`ifdef BCD_CNT_LOAD_CHECK_EN
        check("bad_load_hold_q", 32'(q), 32'h4321);
        check("bad_load_err", 32'(Load_err), 32'h1);
        Load = 1'b0;
        cyc();
        check("bad_load_err_pulse", 32'(Load_err), 32'h0);
`else
        check("raw_load_q", 32'(q), 32'h12A4);
        check("raw_load_err", 32'(Load_err), 32'h0);
        Load = 1'b0; Cin = 1'b1; Up = 1'b1;
        cyc();
        // digit 0 is 4, so nothing ripples into the illegal digit
        check("illegal_step_q", 32'(q), 32'h12A5);
        Cin = 1'b0; Load = 1'b1; Load_val = 16'h12A9;
        cyc();
        Load = 1'b0; Cin = 1'b1; Up = 1'b1;
        cyc();
        check("illegal_up_nocarry", 32'(q), 32'h1200);
        Cin = 1'b0; Load = 1'b1; Load_val = 16'h12A0;
        cyc();
        Load = 1'b0; Cin = 1'b1; Up = 1'b0;
        cyc();
        check("illegal_dn_noborrow", 32'(q), 32'h1299);
        Cin = 1'b0;
`endif

        // cascade of two 2-digit counters
        c_cin = 1'b1;
        repeat (150) cyc();
        c_cin = 1'b0;
        cyc();
        check("cascade_150", 32'({hi_q, lo_q}), 32'h0150);

        // mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            Cin  = 1'($urandom_range(0, 3) != 0);
            Up   = 1'($urandom_range(0, 1));
            Clr  = 1'($urandom_range(0, 40) == 0);
            Load = 1'($urandom_range(0, 12) == 0);
            for (int k = 0; k < 4; k++) begin
                Load_val[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'(9) :
                                     ($urandom_range(0, 5) == 0) ? 4'(0) :
                                     4'($urandom_range(0, 11));
            end
            cyc();
        end
        Cin = 1'b0; Clr = 1'b0; Load = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
